stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for a cascaded BCD decade counter chain: run/pause/resume/clear control and terminal-count detection. Provides the synchronous, enable-gated replacement for the ripple-clocked mod-10 stages. A shared prescaler `tick` strobe advances the count, so every stage sits on the single system clock. Sits between front-panel/debounced control inputs and the seven-segment display drivers.

## Interface
- `DIGITS`, 2: number of BCD decades; count width is 4*DIGITS.
- `clk` input 1: system clock; all state on rising edge.
- `clear` input 1: asynchronous, active-low reset.
- `tick` input 1: count-enable strobe from prescaler; sampled each `clk`.
- `start` input 1: level, sampled per cycle; start/resume.
- `stop` input 1: level; pause.
- `zero` input 1: synchronous count clear and return to IDLE.
- `limit` input 4*DIGITS: BCD terminal value; digit i at bits [4i+3:4i].
- `count` output 4*DIGITS: BCD count, digit 0 least significant.
- `running` output 1: high while in RUN.
- `done` output 1: one-cycle pulse on reaching `limit`.
- `lap_count` output 4*DIGITS: captured count (only with `STOPWATCH_LAP_EN`).
- `lap` input 1: capture request (only with `STOPWATCH_LAP_EN`).

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset (`clear`=0): state IDLE, `count`=0, `running`=0, `done`=0, `lap_count`=0; immediate, independent of `clk`.
- Input priority each cycle: `zero` > `stop` > `start`.
- `zero`=1 in any state: next `count`=0, next state IDLE.
- IDLE: `start` -> RUN; `count` held.
- RUN: `stop` -> PAUSE (a `tick` in the same cycle is discarded). Otherwise, on `tick`, `count` increments:
  - BCD increment: digit 0 +1; a digit at 9 goes to 0 and carries into the next digit.
  - All-9s wraps to all-0s.
  - If the incremented value equals `limit`: next state DONE, `done`=1 for that one cycle.
- PAUSE: `start` -> RUN; `count` held; `tick` ignored.
- DONE: `count` held at `limit`; `start` -> `count`=0 and RUN in the same edge; `tick` ignored.
- `tick` outside RUN: no effect.
- `start` and `stop` both high in RUN: stop wins -> PAUSE.
- `start` and `stop` both high in PAUSE or IDLE: `start` takes effect only if `stop`=0; otherwise the state is held.
- `limit`=0: DONE is reached on the all-9s -> 0 wrap.
- `limit` containing any digit >9: never matched; the counter wraps freely.
- `limit` is sampled combinationally against the incremented value; changes mid-run take effect on the next `tick`.
- `tick` held high in RUN: count advances every cycle.

## Timing
- All outputs are registered.
- `count` changes on the first rising edge after `tick` is sampled high in RUN; latency 1 cycle.
- `done` is asserted in the same cycle that `count` first shows `limit`, and is low the following cycle.
- `running` reflects the state register: high the cycle after `start` is accepted, low the cycle after `stop`, `zero`, or the DONE transition.
- `clear` asserted mid-count: outputs go to reset values without waiting for a clock edge.
- Deassertion of `clear` is synchronized externally.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - `lap` and `lap_count` ports exist.
  - `lap`=1 in RUN or PAUSE loads `lap_count` with the current `count` (pre-increment value if `tick` is coincident).
  - `zero` clears `lap_count` to 0; `lap` in IDLE or DONE is ignored.
- `STOPWATCH_LAP_EN` undefined: ports and register are absent; all other behaviour is identical.

## Test plan
- Reset/start: `clear` low then high, `limit`=8'h25, `start` 1 cycle, then 25 `tick`s -> `count` steps 00..25 in BCD. 09->10 and 19->20 carry checked. `done` high exactly with `count`=25; state DONE; `running`=0.
- Pause/resume: RUN at 8'h07, `stop` with coincident `tick` -> `count` stays 07 and state PAUSE. 3 `tick`s -> 07. `start` then `tick` -> 08.
- Wrap: `limit`=8'hA0, run from 00 through 100 `tick`s -> 99 then 00, `done` never asserted. Repeat with `limit`=0 -> `done` on the 99->00 step.
- Priority: in RUN assert `zero`, `stop`, `start` together -> `count`=00, IDLE, `running`=0.
- Async reset: assert `clear` between clock edges at `count`=8'h42 -> `count`=0 before the next edge.
- Lap (macro on): `lap` at `count`=8'h13 with coincident `tick` -> `lap_count`=13, `count`=14. `zero` -> `lap_count`=00.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for a cascaded BCD decade counter with terminal-count pulse.
// Optional lap capture register is compiled in when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  zero,
  input  logic [4*DIGITS-1:0]   limit,
`ifdef STOPWATCH_LAP_EN
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   lap_count,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done
);

  localparam int W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]   state_reg, state_next;
  logic [W-1:0] count_reg, count_next;
  logic         done_reg, done_next;
  logic         running_reg;
  logic [W-1:0] count_inc;
  logic [DIGITS-1:0] carry;
  logic         start_ok;

  // Ripple-free BCD increment: each decade advances only when all lower decades sit at 9.
  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic       at_nine;
      assign digit   = count_reg[4*gi +: 4];
      assign at_nine = (digit == 4'd9);
      assign count_inc[4*gi +: 4] = !carry[gi] ? digit : (at_nine ? 4'd0 : digit + 4'd1);
      if (gi < DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & at_nine;
      end
    end
  endgenerate

  // stop outranks start whenever both are high
  assign start_ok = start & ~stop;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    if (zero) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_PAUSE: begin
          if (start_ok) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_next = ST_PAUSE;
          end else if (tick) begin
            count_next = count_inc;
            // a limit digit above 9 can never equal a valid BCD value, so it never matches
            if (count_inc == limit) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start_ok) begin
            count_next = '0;
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      done_reg    <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      done_reg    <= done_next;
      running_reg <= (state_next == ST_RUN);
    end
  end

  assign count   = count_reg;
  assign running = running_reg;
  assign done    = done_reg;

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap_reg, lap_next;

  // capture the value shown this cycle, before any coincident tick lands
  always_comb begin
    lap_next = lap_reg;
    if (zero) begin
      lap_next = '0;
    end else if (lap && (state_reg == ST_RUN || state_reg == ST_PAUSE)) begin
      lap_next = count_reg;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      lap_reg <= '0;
    end else begin
      lap_reg <= lap_next;
    end
  end

  assign lap_count = lap_reg;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a decimal-arithmetic reference model queues expected
// outputs per cycle; independent monitors pop and compare after each edge and after async reset.
module tb_stopwatch_ctrl;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MODV   = 100;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         tick = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         zero = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] count;
  logic         running;
  logic         done;
`ifdef STOPWATCH_LAP_EN
  logic         lap = 1'b0;
  logic [W-1:0] lap_count;
`endif

  stopwatch_ctrl #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .clear    (clear),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .zero     (zero),
    .limit    (limit),
`ifdef STOPWATCH_LAP_EN
    .lap      (lap),
    .lap_count(lap_count),
`endif
    .count    (count),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef enum {P_IDLE, P_RUN, P_PAUSE, P_DONE} phase_t;

  typedef struct {
    logic [W-1:0] cnt;
    bit           run;
    bit           dn;
    logic [W-1:0] lapv;
  } exp_t;

  exp_t clk_q[$];
  exp_t async_q[$];

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // reference model: count kept as a plain decimal integer
  phase_t m_phase = P_IDLE;
  int     m_val   = 0;
  int     m_lap   = 0;
  bit     m_done  = 1'b0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int limit_value(input logic [W-1:0] l);
    int v;
    int p;
    v = 0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (l[4*d +: 4] > 4'd9) return -1;
      v = v + int'(l[4*d +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.cnt  = to_bcd(m_val);
    e.run  = (m_phase == P_RUN);
    e.dn   = m_done;
    e.lapv = to_bcd(m_lap);
    return e;
  endfunction

  task automatic compare(input exp_t e, input string tag);
    txn++;
    $display("txn %0d %s count=%h running=%b done=%b", txn, tag, count, running, done);
    checks++;
    if (count !== e.cnt) begin
      errors++;
      $display("FAIL %s count: got %h want %h (txn %0d)", tag, count, e.cnt, txn);
    end
    checks++;
    if (running !== e.run) begin
      errors++;
      $display("FAIL %s running: got %b want %b (txn %0d)", tag, running, e.run, txn);
    end
    checks++;
    if (done !== e.dn) begin
      errors++;
      $display("FAIL %s done: got %b want %b (txn %0d)", tag, done, e.dn, txn);
    end
`ifdef STOPWATCH_LAP_EN
    checks++;
    if (lap_count !== e.lapv) begin
      errors++;
      $display("FAIL %s lap_count: got %h want %h (txn %0d)", tag, lap_count, e.lapv, txn);
    end
`endif
  endtask

  // one clock of stimulus, applied at the falling edge
  task automatic step(input bit t, input bit s, input bit p, input bit z, input bit l);
    int lim;
    tick  = t;
    start = s;
    stop  = p;
    zero  = z;
`ifdef STOPWATCH_LAP_EN
    lap   = l;
`endif
    lim    = limit_value(limit);
    m_done = 1'b0;
    if (z) begin
      m_val   = 0;
      m_lap   = 0;
      m_phase = P_IDLE;
    end else begin
      if (l && (m_phase == P_RUN || m_phase == P_PAUSE)) m_lap = m_val;
      case (m_phase)
        P_IDLE, P_PAUSE: if (s && !p) m_phase = P_RUN;
        P_RUN: begin
          if (p) begin
            m_phase = P_PAUSE;
          end else if (t) begin
            m_val = (m_val + 1) % MODV;
            if (m_val == lim) begin
              m_phase = P_DONE;
              m_done  = 1'b1;
            end
          end
        end
        P_DONE: if (s && !p) begin
          m_val   = 0;
          m_phase = P_RUN;
        end
        default: ;
      endcase
    end
    clk_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // assert clear between edges, hold two cycles, release on a falling edge
  task automatic async_reset();
    #2;
    m_phase = P_IDLE;
    m_val   = 0;
    m_lap   = 0;
    m_done  = 1'b0;
    async_q.push_back(model_out());
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    zero  = 1'b0;
    clear = 1'b1;
  endtask

  // clocked monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (clk_q.size() > 0) begin
        e = clk_q.pop_front();
        compare(e, "clk");
      end
    end
  end

  // asynchronous-reset monitor: outputs must already be cleared before any edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clear);
      #1;
      if (async_q.size() > 0) begin
        e = async_q.pop_front();
        compare(e, "async");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    #1;
    async_q.push_back(model_out());
    clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;

    // count 00..25 with carries, done pulse, then idle in DONE
    limit = 8'h25;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(25);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // pause with coincident tick, ticks ignored, resume
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(7);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // invalid limit: free wrap; zero limit: done on 99->00
    limit = 8'hA0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(100);
    limit = 8'h00;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // restart from DONE, then zero/stop/start together
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // lap capture at 13 with coincident tick, then zero clears it
    limit = 8'hA0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(13);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // asynchronous clear at 42
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(42);
    async_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized traffic with occasional limit changes
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99, 0) < 4) begin
        r = int'($urandom_range(9, 0));
        if ($urandom_range(3, 0) == 0) limit = {4'($urandom_range(15, 10)), 4'(r)};
        else limit = {4'($urandom_range(9, 0)), 4'(r)};
      end
      step(($urandom_range(99, 0) < 75),
           ($urandom_range(99, 0) < 15),
           ($urandom_range(99, 0) < 8),
           ($urandom_range(99, 0) < 2),
           ($urandom_range(99, 0) < 10));
    end

    @(posedge clk);
    #2;
    if (clk_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", clk_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
